// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = x - y as a (W+1)-bit two's-complement value,
// computed LSB first with one borrow flip-flop, valid/ready on both sides.
module serial_subtractor #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   d
);

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic [W:0]    r_d;

  logic          w_accept;
  logic          w_last;
  logic          w_dbit;
  logic          w_borrow_next;
  logic [W-1:0]  w_res_next;

  assign w_accept      = in_valid && (r_state == IDLE);
  assign w_last        = (r_state == RUN) && (r_cnt == LAST);
  assign w_dbit        = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrow_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  assign w_res_next    = {w_dbit, r_res[W-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred when a case branch leaves the state unchanged.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
    end else if (w_accept) begin
      r_a      <= x;
      r_b      <= y;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_cnt    <= r_cnt + 1'b1;
      r_borrow <= w_borrow_next;
      // The final borrow is the sign bit of the difference.
      if (w_last) begin
        r_d <= {w_borrow_next, w_res_next};
      end
    end
  end

  // Handshake flags are pure state decodes: no combinational path from inputs.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign d         = r_d;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus a random
// back-to-back run checked against a scoreboard of expected differences.
module tb_serial_subtractor;

  localparam int W = 6;
  localparam int N_RANDOM = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   d;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b};
    return r;
  endfunction

  // Presents one operand pair in IDLE, then counts edges from the accepting
  // edge until out_valid is seen (bounded).
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, output int lat);
    in_valid = 1'b1;
    x = xv;
    y = yv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    x = 6'd11;
    y = 6'd22;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL reset_d: got %b want 0", d);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    exp_q.push_back(7'b0011011);
    run_op(6'd45, 6'd18, lat);
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL basic_d: got %b want %b", d, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes;
    logic [W-1:0] xs[4] = '{6'd0, 6'd32, 6'd63, 6'd63};
    logic [W-1:0] ys[4] = '{6'd63, 6'd33, 6'd63, 6'd0};
    logic [W:0]   es[4] = '{7'b1000001, 7'b1111111, 7'b0000000, 7'b0111111};
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(es[i]);
      run_op(xs[i], ys[i], lat);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL extreme_%0d: got valid=%b d=%b want valid=1 d=%b", i, out_valid, d, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [W:0] e;
    out_ready = 1'b0;
    exp_q.push_back(7'b0000111);
    run_op(6'd10, 6'd3, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want %0d", lat, W);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== e) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got valid=%b ready=%b d=%b want 1/0/%b",
                 i, out_valid, in_ready, d, e);
      end
      in_valid = 1'b1;
      x = W'($urandom);
      y = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || d !== e) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b d=%b want 0/%b", out_valid, d, e);
    end
  endtask

  task automatic test_ignored;
    int pulses;
    logic prev;
    logic [W:0] e;
    out_ready = 1'b1;
    exp_q.push_back(model(6'd13, 6'd50));
    in_valid = 1'b1;
    x = 6'd13;
    y = 6'd50;
    @(posedge clk); #1;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (out_valid && !prev) begin
        pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL ignored_d: got %b want %b", d, e);
        end
      end
      prev = out_valid;
      if (out_valid || pulses > 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = ~in_valid;
        x = W'($urandom);
        y = W'($urandom);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL ignored_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 6'd20;
    y = 6'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || d !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_run: got valid=%b d=%b ready=%b want 0/0/1", out_valid, d, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(7'b1111110);
    run_op(6'd7, 6'd9, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat != W || d !== e) begin
      n_fail++;
      $display("FAIL rst_recover: got lat=%0d d=%b want %0d/%b", lat, d, W, e);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(6'd20, 6'd5, lat);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || d !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got valid=%b d=%b want 0/0", out_valid, d);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n_acc = 0;
    int n_out = 0;
    int cyc = 0;
    int edge_n = 0;
    int acc_edge[$];
    int a_edge;
    logic prev_ov = 1'b0;
    logic [W:0] e;
    exp_q.delete();
    while ((n_acc < N_RANDOM || n_out < n_acc) && cyc < 40000) begin
      in_valid  = (n_acc < N_RANDOM);
      x         = W'($urandom);
      y         = W'($urandom);
      out_ready = 1'($urandom);
      if (out_valid && !prev_ov) begin
        a_edge = (acc_edge.size() > 0) ? acc_edge.pop_front() : -1000;
        n_checks++;
        if (edge_n - a_edge != W) begin
          n_fail++;
          $display("FAIL b2b_latency: got %0d want %0d", edge_n - a_edge, W);
        end
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, y));
        acc_edge.push_back(edge_n + 1);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL b2b_d: result %0d got %b want %b", n_out, d, e);
        end
        n_out++;
      end
      @(posedge clk); #1;
      edge_n++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out != N_RANDOM || exp_q.size() != 0 || acc_edge.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, %0d pending want %0d/0",
               n_out, exp_q.size(), N_RANDOM);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial 6-bit subtractor. It computes d = x - y as a 7-bit two's-complement result, one bit per clock, LSB first, using a single borrow flip-flop. It is the sequential, inverse-direction companion to the team's combinational 6-bit prefix adder, and uses the same operand and result widths (x[5:0], y[5:0] in, 7-bit result out). Operands are loaded through a valid/ready input handshake, and the result is returned through a valid/ready output handshake.

Parameters:
W, 6, operand width in bits; result width is W+1; bit counter width is clog2(W+1).

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands x,y valid
in_ready  output  1  block can accept operands
x  input  W  minuend (unsigned)
y  input  W  subtrahend (unsigned)
out_valid  output  1  result d valid
out_ready  input  1  consumer accepts d
d  output  W+1  x - y, two's complement; d[W] = 1 iff x < y

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, d=0, borrow=0, counter=0, shift registers=0. in_ready=1 once rst deasserts. Inputs are ignored while rst=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready is a pure decode of state==IDLE; there is no combinational path from in_valid.
- IDLE -> RUN on in_valid&in_ready at a rising edge:
  - load a<=x, b<=y;
  - borrow<=0, cnt<=0;
  - result shift register cleared.
- RUN, each cycle:
  - dbit = a[0]^b[0]^borrow.
  - borrow <= (~a[0]&b[0]) | (~(a[0]^b[0])&borrow).
  - a,b shift right by 1; dbit shifts into the result MSB (result shifts right).
  - cnt <= cnt+1.
  - After the W-th RUN cycle (cnt==W-1 at the edge), go to HOLD.
  - On that same edge: d <= {borrow_next, result_next}; out_valid <= 1.
- Latency: out_valid rises exactly W clock edges after the accepting edge (6 for default).
- HOLD: d and out_valid are held stable until out_valid&out_ready at an edge. On that edge:
  - out_valid <= 0; state <= IDLE;
  - d holds its last value, and the register is not cleared.
- out_ready is ignored outside HOLD. in_valid is ignored outside IDLE; operands presented during RUN/HOLD are not captured.
- No overlap: minimum initiation interval is W+2 cycles (accept, W RUN, output handshake; IDLE re-entry gives in_ready the following cycle).
- Arithmetic: d = (x - y) mod 2^(W+1), equal to the signed value x-y in range -(2^W-1)..(2^W-1). There is no overflow case. d[W] equals the final borrow.
- Reset mid-operation (RUN or HOLD): immediate abort to IDLE. out_valid drops asynchronously and d=0; no partial result is ever presented.
- Simultaneous in_valid and out_ready in HOLD: only the output handshake is taken; operands are accepted no earlier than the following IDLE cycle.

Test Plan:
- Basic: reset, then present x=45, y=18 with in_valid=1 and out_ready=1. Required: accept on first edge; out_valid high 6 edges later; d=7'b0011011 (27), held 1 cycle; in_ready=1 the next cycle.
- Negative/extremes, each with out_ready=1:
  - x=0, y=63 -> d=7'b1000001 (-63);
  - x=32, y=33 -> d=7'b1111111 (-1);
  - x=63, y=63 -> d=0;
  - x=63, y=0 -> d=7'b0111111.
- Backpressure: x=10, y=3 with out_ready=0 for 5 cycles after out_valid. Required: d=7'b0000111 stable and out_valid=1 throughout; in_ready=0; a changing x/y during the stall is not captured. Raise out_ready -> out_valid falls next edge.
- Ignored inputs: toggle in_valid with new operands during RUN. Required: the result matches the originally accepted operands; exactly one out_valid pulse results.
- Reset mid-RUN: assert rst 3 cycles after accepting x=20, y=5. Required: out_valid=0, d=0, state IDLE immediately. After release, x=7, y=9 yields d=7'b1111110 (-2) with normal latency.
- Random back-to-back: 1000 random x,y pairs with in_valid always high and random out_ready. Required: every d matches the model (x-y) mod 128; the accept-to-out_valid distance is always 6; there are no lost or duplicated results.
